// File: rtl/pcileech_sysrst_ctl.sv
// Board reset/button controller: 2-FF button sync, optional debounce, POR/hold FSM,
// config-reload pulse, power-on blink and uptime. Debounce enabled by PCILEECH_RSTCTL_DEBOUNCE_EN.
module pcileech_sysrst_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
)(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], ~btn_n};
  end

`ifdef PCILEECH_RSTCTL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Count consecutive cycles the synced level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_q[1] == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filt <= sync_q[1];
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign pressed = filt;
`else
  assign pressed = sync_q[1];
`endif
endmodule

module pcileech_sysrst_ctl #(
  parameter int unsigned POR_CYCLES       = 64,
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned RELOAD_CYCLES    = 500000000,
  parameter int unsigned BLINK_BIT        = 24,
  parameter int unsigned BLINK_WINDOW_BIT = 27
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  output logic        rst_sys,
  output logic        ft601_rst_n,
  output logic        rst_cfg_reload,
  output logic        led_pwronblink,
  output logic [63:0] uptime
);
  localparam int NUM_LANES = 2;
  localparam int POR_W     = $clog2(POR_CYCLES + 1);
  localparam int HOLD_W    = $clog2(RELOAD_CYCLES + 1);

  localparam logic [1:0] S_POR  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [NUM_LANES-1:0] btn_n, btn_p;
  logic                 sw1_p, sw2_p, blink_win;
  logic [1:0]           state;
  logic [POR_W-1:0]     por_cnt;
  logic [HOLD_W-1:0]    hold_cnt;

  assign btn_n = {user_sw2_n, user_sw1_n};

  pcileech_sysrst_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_LANES-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .pressed (btn_p)
  );

  assign sw1_p     = btn_p[0];
  assign sw2_p     = btn_p[1];
  assign blink_win = (uptime[63:BLINK_WINDOW_BIT] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_POR;
      por_cnt        <= '0;
      hold_cnt       <= '0;
      uptime         <= '0;
      rst_sys        <= 1'b1;
      ft601_rst_n    <= 1'b0;
      rst_cfg_reload <= 1'b0;
      led_pwronblink <= 1'b0;
    end else begin
      rst_cfg_reload <= 1'b0;
      rst_sys        <= (state != S_RUN);
      ft601_rst_n    <= (state == S_RUN);
      led_pwronblink <= sw1_p ^ (uptime[BLINK_BIT] & blink_win);
      uptime         <= (state == S_RUN) ? uptime + 64'd1 : '0;
      case (state)
        S_POR: begin
          // A held reset button wins over POR completion.
          if (sw2_p) begin
            state    <= S_HOLD;
            por_cnt  <= '0;
            hold_cnt <= '0;
          end else if (por_cnt == POR_W'(POR_CYCLES - 1)) begin
            state   <= S_RUN;
            por_cnt <= '0;
          end else begin
            por_cnt <= por_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (sw2_p) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (!sw2_p) begin
            state    <= S_POR;
            por_cnt  <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_W'(RELOAD_CYCLES)) begin
            // Saturating count makes the reload pulse one-shot per hold.
            hold_cnt       <= hold_cnt + 1'b1;
            rst_cfg_reload <= (hold_cnt == HOLD_W'(RELOAD_CYCLES - 1));
          end
        end
        default: state <= S_POR;
      endcase
    end
  end
endmodule

// File: tb/tb_pcileech_sysrst_ctl.sv
// Bench for pcileech_sysrst_ctl: vector table, hand-written corner sequences and
// randomized button/reset stimulus checked against a phase-duration reference model.
module tb_pcileech_sysrst_ctl;
  localparam int POR = 8, DEB = 4, REL = 20, BB = 2, BWB = 4;
`ifdef PCILEECH_RSTCTL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int LAT = DEB_EN ? DEB : 0;
  localparam int P_POR = 0, P_RUN = 1, P_HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sw1_n, sw2_n;
  logic        rst_sys, ft601_rst_n, rst_cfg_reload, led_pwronblink;
  logic [63:0] uptime;

  pcileech_sysrst_ctl #(
    .POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB), .RELOAD_CYCLES(REL),
    .BLINK_BIT(BB), .BLINK_WINDOW_BIT(BWB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .user_sw1_n(sw1_n), .user_sw2_n(sw2_n),
    .rst_sys(rst_sys), .ft601_rst_n(ft601_rst_n), .rst_cfg_reload(rst_cfg_reload),
    .led_pwronblink(led_pwronblink), .uptime(uptime)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: synced samples, filtered flags, phase and time spent in it.
  bit        m_s0[2], m_s1[2], m_filt[2];
  bit        q0[$], q1[$];
  int        m_ph, m_el;
  bit [63:0] m_up;
  bit        m_rst, m_led, m_pulse;

  function automatic bit flips(input bit q[$], input bit lvl);
    if (q.size() < DEB) return 1'b0;
    for (int k = q.size() - DEB; k < q.size(); k++)
      if (q[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_step();
    bit p[2], prs[2];
    int nph;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin m_s0[b] = 0; m_s1[b] = 0; m_filt[b] = 0; end
      q0.delete(); q1.delete();
      m_ph = P_POR; m_el = 0; m_up = 0; m_rst = 1; m_led = 0; m_pulse = 0;
      return;
    end
    prs[0] = !sw1_n; prs[1] = !sw2_n;
    for (int b = 0; b < 2; b++) p[b] = DEB_EN ? m_filt[b] : m_s1[b];
    if (DEB_EN) begin
      q0.push_back(m_s1[0]); q1.push_back(m_s1[1]);
      if (q0.size() > DEB) void'(q0.pop_front());
      if (q1.size() > DEB) void'(q1.pop_front());
      if (flips(q0, m_filt[0])) m_filt[0] = m_s1[0];
      if (flips(q1, m_filt[1])) m_filt[1] = m_s1[1];
    end
    for (int b = 0; b < 2; b++) begin m_s1[b] = m_s0[b]; m_s0[b] = prs[b]; end
    m_rst   = (m_ph != P_RUN);
    m_led   = p[0] ^ (m_up[BB] && (m_up < (64'd1 << BWB)));
    m_pulse = (m_ph == P_HOLD) && p[1] && (m_el + 1 == REL);
    m_up    = (m_ph == P_RUN) ? m_up + 64'd1 : 64'd0;
    nph = m_ph;
    case (m_ph)
      P_POR:   if (p[1]) nph = P_HOLD; else if (m_el + 1 == POR) nph = P_RUN;
      P_RUN:   if (p[1]) nph = P_HOLD;
      default: if (!p[1]) nph = P_POR;
    endcase
    m_el = (nph != m_ph) ? 0 : m_el + 1;
    m_ph = nph;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check("rst_sys", rst_sys, m_rst);
    check("ft601_rst_n", ft601_rst_n, !m_rst);
    check("rst_cfg_reload", rst_cfg_reload, m_pulse);
    check("led_pwronblink", led_pwronblink, m_led);
    check("uptime", uptime, m_up);
  endtask

  typedef struct {
    bit rst_n; bit sw1_n; bit sw2_n; int cyc;
    bit e_rst; bit e_led; logic [63:0] e_up;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int first, cnt, pulses;
    rst_n = 0; sw1_n = 1; sw2_n = 1;
    tbl[0] = '{0, 1, 1, 3,  1, 0, 64'd0};
    tbl[1] = '{1, 1, 1, 8,  1, 0, 64'd0};
    tbl[2] = '{1, 1, 1, 1,  0, 0, 64'd1};
    tbl[3] = '{1, 1, 1, 4,  0, 1, 64'd5};
    tbl[4] = '{1, 1, 1, 11, 0, 1, 64'd16};
    tbl[5] = '{1, 1, 1, 1,  0, 0, 64'd17};
    tbl[6] = '{1, 0, 1, 10, 0, 1, 64'd27};
    tbl[7] = '{1, 1, 1, 10, 0, 0, 64'd37};
    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n; sw1_n = tbl[i].sw1_n; sw2_n = tbl[i].sw2_n;
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d rst_sys", i), rst_sys, tbl[i].e_rst);
      check($sformatf("vec%0d ft601", i), ft601_rst_n, !tbl[i].e_rst);
      check($sformatf("vec%0d led", i), led_pwronblink, tbl[i].e_led);
      check($sformatf("vec%0d uptime", i), uptime, tbl[i].e_up);
      check($sformatf("vec%0d reload", i), rst_cfg_reload, 0);
    end

    // Short sw2 press: reset for the hold plus a full POR, no reload.
    first = -1; cnt = 0; pulses = 0;
    for (int t = 1; t <= 60; t++) begin
      sw2_n = (t <= 10) ? 1'b0 : 1'b1;
      tick();
      if (rst_sys) begin cnt++; if (first < 0) first = t; end
      if (rst_cfg_reload) pulses++;
      if (t > 1 && !rst_sys && cnt > 0 && first > 0) begin
        check("short press uptime restart", uptime, 64'd1);
        first = -first;
      end
    end
    check("short press rst start", -first, 4 + LAT);
    check("short press rst cycles", cnt, 10 + POR);
    check("short press pulses", pulses, 0);

    // Long hold: one pulse RELOAD cycles after hold entry.
    first = -1; pulses = 0;
    for (int t = 1; t <= 80; t++) begin
      sw2_n = (t <= 50) ? 1'b0 : 1'b1;
      tick();
      if (rst_cfg_reload) begin pulses++; if (first < 0) first = t; end
    end
    check("long hold pulse count", pulses, 1);
    check("long hold pulse time", first, 3 + LAT + REL);

    // Bounce shorter than the filter window.
    cnt = 0;
    for (int r = 0; r < 5; r++)
      for (int t = 0; t < 6; t++) begin
        sw2_n = (t < 3) ? 1'b0 : 1'b1;
        tick();
        if (rst_sys) cnt++;
      end
    sw2_n = 1;
    repeat (30) begin tick(); if (rst_sys) cnt++; end
    check("bounce enters hold", cnt > 0, !DEB_EN);
    repeat (20) tick();

    // Reset during hold one cycle before the reload pulse.
    pulses = 0;
    sw2_n = 0;
    repeat (3 + LAT + REL - 1) begin tick(); if (rst_cfg_reload) pulses++; end
    rst_n = 0; sw2_n = 1;
    repeat (2) begin tick(); if (rst_cfg_reload) pulses++; end
    check("abort rst_sys", rst_sys, 1);
    check("abort ft601", ft601_rst_n, 0);
    check("abort led", led_pwronblink, 0);
    check("abort uptime", uptime, 64'd0);
    rst_n = 1;
    repeat (30) begin tick(); if (rst_cfg_reload) pulses++; end
    check("abort pulses", pulses, 0);

    // Randomized segments.
    for (int s = 0; s < 120; s++) begin
      int len;
      len   = $urandom_range(1, 45);
      sw1_n = $urandom_range(0, 1);
      sw2_n = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 19) != 0);
      if (!rst_n) len = $urandom_range(1, 3);
      repeat (len) tick();
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
